// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction-fetch stage with IF/ID pipeline register. Keeps the
//             PC, issues single-outstanding imem requests (req/gnt/rvalid),
//             applies decode-stage PC redirects and kills the delay slot of
//             compact branches (OFFSET_26).
//  Options  : PFU_ALIGN_CHECK_EN - adds sticky fetch_misalign output that
//             halts fetching on a misaligned redirect target.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int                 ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        pcsrc,
    input  logic              pause,
    input  logic [31:0]       rs_data,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              id_valid,
    output logic [31:0]       id_instr,
    output logic [ADDR_W-1:0] id_pc
`ifdef PFU_ALIGN_CHECK_EN
    ,
    output logic              fetch_misalign
`endif
);

    localparam logic [2:0] c_OP_NEXT      = 3'd0;
    localparam logic [2:0] c_OP_OFFSET_16 = 3'd1;
    localparam logic [2:0] c_OP_OFFSET_26 = 3'd2;
    localparam logic [2:0] c_OP_JUMP      = 3'd3;
    localparam logic [2:0] c_OP_RS        = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_inflight_pc;
    logic [ADDR_W-1:0] r_skid_pc;
    logic [31:0]       r_skid_instr;
    logic              r_req;
    logic              r_kill;
    logic              r_id_valid;
    logic [31:0]       r_id_instr;
    logic [ADDR_W-1:0] r_id_pc;

    logic              w_is_jump_op;
    logic              w_redirect;
    logic              w_kill_ds;
    logic              w_gnt;
    logic              w_req_ok;
    logic [ADDR_W-1:0] w_p4;
    logic [ADDR_W-1:0] w_target_raw;
    logic [ADDR_W-1:0] w_target;

    // Redirect target computed from the instruction currently held in ID
    always_comb begin
        w_p4         = r_id_pc + ADDR_W'(4);
        w_target_raw = w_p4;
        w_is_jump_op = 1'b1;
        case (pcsrc)
            c_OP_OFFSET_16: w_target_raw = w_p4 + {{(ADDR_W-18){r_id_instr[15]}}, r_id_instr[15:0], 2'b00};
            c_OP_OFFSET_26: w_target_raw = w_p4 + {{(ADDR_W-28){r_id_instr[25]}}, r_id_instr[25:0], 2'b00};
            c_OP_JUMP:      w_target_raw = {w_p4[ADDR_W-1:28], r_id_instr[25:0], 2'b00};
            c_OP_RS:        w_target_raw = rs_data[ADDR_W-1:0];
            default:        w_is_jump_op = 1'b0;
        endcase
        // Instruction fetches are always word aligned
        w_target = w_target_raw & ~ADDR_W'(3);
    end

    // A redirect only happens for a real instruction on an unpaused cycle
    assign w_redirect = r_id_valid && !pause && w_is_jump_op && (pcsrc != c_OP_NEXT);
    assign w_kill_ds  = w_redirect && (pcsrc == c_OP_OFFSET_26);
    assign w_gnt      = r_req && imem_gnt && (r_state == S_IDLE);

`ifdef PFU_ALIGN_CHECK_EN
    logic r_misalign;
    logic w_target_bad;

    assign w_target_bad   = |w_target_raw[1:0];
    assign fetch_misalign = r_misalign;
    // Fetching stops for good once a misaligned target is seen
    assign w_req_ok       = !r_misalign && !(w_redirect && w_target_bad);

    // Sticky misalignment flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
        end else if (w_redirect && w_target_bad) begin
            r_misalign <= 1'b1;
        end
    end
`else
    assign w_req_ok = 1'b1;
`endif

    // Fetch FSM, PC, skid buffer and IF/ID register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_inflight_pc <= RESET_PC;
            r_skid_pc     <= RESET_PC;
            r_skid_instr  <= 32'h0;
            r_req         <= 1'b0;
            r_kill        <= 1'b0;
            r_id_valid    <= 1'b0;
            r_id_instr    <= 32'h0;
            r_id_pc       <= RESET_PC;
        end else begin
            // ID consumed its instruction: bubble unless something is loaded below
            if (!pause) begin
                r_id_valid <= 1'b0;
                r_id_instr <= 32'h0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_gnt) begin
                        r_pc          <= r_pc + ADDR_W'(4);
                        r_inflight_pc <= r_pc;
                        r_state       <= S_WAIT;
                        r_req         <= 1'b0;
                        // The fetch granted alongside a compact branch is its delay slot
                        if (w_kill_ds) begin
                            r_kill <= 1'b1;
                        end
                    end else begin
                        r_req <= w_req_ok;
                    end
                end
                S_WAIT: begin
                    r_req <= 1'b0;
                    if (imem_rvalid) begin
                        if (r_kill || w_kill_ds) begin
                            r_kill  <= 1'b0;
                            r_state <= S_IDLE;
                            r_req   <= w_req_ok;
                        end else if (!pause) begin
                            r_id_valid <= 1'b1;
                            r_id_instr <= imem_rdata;
                            r_id_pc    <= r_inflight_pc;
                            r_state    <= S_IDLE;
                            r_req      <= w_req_ok;
                        end else begin
                            r_skid_instr <= imem_rdata;
                            r_skid_pc    <= r_inflight_pc;
                            r_state      <= S_HOLD;
                        end
                    end else if (w_kill_ds) begin
                        r_kill <= 1'b1;
                    end
                end
                S_HOLD: begin
                    r_req <= 1'b0;
                    if (!pause) begin
                        // A compact branch discards the parked delay slot
                        if (!w_kill_ds) begin
                            r_id_valid <= 1'b1;
                            r_id_instr <= r_skid_instr;
                            r_id_pc    <= r_skid_pc;
                        end
                        r_state <= S_IDLE;
                        r_req   <= w_req_ok;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
            // Redirect wins over the +4 of a same-cycle grant
            if (w_redirect) begin
                r_pc <= w_target;
            end
        end
    end

    assign imem_req  = r_req;
    assign imem_addr = r_pc;
    assign id_valid  = r_id_valid;
    assign id_instr  = r_id_instr;
    assign id_pc     = r_id_pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Directed self-checking bench for fetch_unit with a small
//             instruction-memory responder (optional PFU_ALIGN_CHECK_EN).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  pcsrc;
    logic        pause;
    logic [31:0] rs_data;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
`ifdef PFU_ALIGN_CHECK_EN
    logic        fetch_misalign;
`endif

    int errors = 0;
    int checks = 0;

    // Memory responder controls and state
    logic        gnt_en  = 1'b1;
    logic        resp_en = 1'b1;
    logic        pend    = 1'b0;
    logic [31:0] paddr   = 32'h0;
    logic [31:0] gaddr [0:255];
    int          gcount  = 0;

    fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_3000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pcsrc       (pcsrc),
        .pause       (pause),
        .rs_data     (rs_data),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc)
`ifdef PFU_ALIGN_CHECK_EN
        ,
        .fetch_misalign (fetch_misalign)
`endif
    );

    always #5 clk = ~clk;

    // Program image: beq at 0x3010, bc at 0x3020, filler elsewhere
    function automatic logic [31:0] instr_at(input logic [31:0] a);
        case (a)
            32'h0000_3010: return 32'h1000_0003;
            32'h0000_3020: return 32'hCBFF_FFFE;
            default:       return 32'h2400_0000 | {16'h0, a[15:0]};
        endcase
    endfunction

    assign imem_gnt    = gnt_en & imem_req;
    assign imem_rvalid = pend & resp_en;
    assign imem_rdata  = instr_at(paddr);

    // One-outstanding memory: response follows the grant, grants are logged
    always @(posedge clk) begin
        if (imem_rvalid) pend <= 1'b0;
        if (imem_req && imem_gnt) begin
            pend           <= 1'b1;
            paddr          <= imem_addr;
            gaddr[gcount]  <= imem_addr;
            gcount         <= gcount + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until IF/ID holds a real instruction, bounded
    task automatic wait_id(input int maxc);
        int n = 0;
        do begin
            tick();
            n++;
        end while (id_valid !== 1'b1 && n < maxc);
        checks++;
        assert (id_valid === 1'b1) else begin
            errors++;
            $error("FAIL wait_id_timeout: observed id_valid=%b expected 1 within %0d cycles", id_valid, maxc);
        end
    endtask

    function automatic logic [31:0] last_grant();
        if (gcount == 0) return 32'hFFFF_FFFF;
        return gaddr[gcount-1];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        pcsrc   = 3'd0;
        pause   = 1'b0;
        rs_data = 32'h0;

        // ---- Reset state ----
        tick();
        tick();
        chk("rst_req",      {31'h0, imem_req}, 32'h0);
        chk("rst_addr",     imem_addr,         32'h3000);
        chk("rst_id_valid", {31'h0, id_valid}, 32'h0);
        chk("rst_id_instr", id_instr,          32'h0);
        chk("rst_id_pc",    id_pc,             32'h3000);
`ifdef PFU_ALIGN_CHECK_EN
        chk("rst_misalign", {31'h0, fetch_misalign}, 32'h0);
`endif
        #3 rst_n = 1'b1;

        // ---- Sequential fetch ----
        wait_id(8);
        chk("seq_pc0",    id_pc,    32'h3000);
        chk("seq_instr0", id_instr, 32'h2400_3000);
        chk("seq_addr1",  imem_addr, 32'h3004);
        tick();
        chk("seq_bubble_valid", {31'h0, id_valid}, 32'h0);
        chk("seq_bubble_instr", id_instr, 32'h0);
        wait_id(8);
        chk("seq_pc1", id_pc, 32'h3004);
        wait_id(8);
        chk("seq_pc2",   id_pc,    32'h3008);
        chk("grant0",    gaddr[0], 32'h3000);
        chk("grant1",    gaddr[1], 32'h3004);
        chk("grant2",    gaddr[2], 32'h3008);
        for (int i = 0; i < 6 && id_pc !== 32'h3010; i++) wait_id(8);
        chk("beq_in_id", id_pc, 32'h3010);

        // ---- beq: delay slot kept, target 0x3014 + 12 ----
        pcsrc = 3'd1;
        tick();
        pcsrc = 3'd0;
        chk("beq_target",     imem_addr,    32'h3020);
        chk("beq_slot_grant", last_grant(), 32'h3014);
        wait_id(8);
        chk("beq_slot_in_id", id_pc, 32'h3014);
        wait_id(8);
        chk("bc_in_id",    id_pc,    32'h3020);
        chk("bc_instr",    id_instr, 32'hCBFF_FFFE);

        // ---- bc: delay slot 0x3024 parked in WAIT, then killed ----
        pause   = 1'b1;
        resp_en = 1'b0;
        tick();
        chk("bc_freeze_pc",   id_pc,     32'h3020);
        chk("bc_wait_addr",   imem_addr, 32'h3028);
        pause = 1'b0;
        pcsrc = 3'd2;
        tick();
        pcsrc = 3'd0;
        chk("bc_target",      imem_addr,         32'h301C);
        chk("bc_bubble",      {31'h0, id_valid}, 32'h0);
        chk("bc_req_wait",    {31'h0, imem_req}, 32'h0);
        resp_en = 1'b1;
        tick();
        chk("bc_drop_valid",  {31'h0, id_valid}, 32'h0);
        chk("bc_drop_instr",  id_instr,          32'h0);
        chk("bc_req_again",   {31'h0, imem_req}, 32'h1);
        wait_id(8);
        chk("bc_next_pc",     id_pc,    32'h301C);
        chk("bc_next_instr",  id_instr, 32'h2400_301C);

        // ---- jr under 3 paused cycles ----
        pause   = 1'b1;
        pcsrc   = 3'd4;
        rs_data = 32'h0000_4000;
        tick();
        chk("jr_p1_pc",   id_pc,     32'h301C);
        chk("jr_p1_addr", imem_addr, 32'h3024);
        tick();
        chk("jr_p2_pc",   id_pc,             32'h301C);
        chk("jr_p2_req",  {31'h0, imem_req}, 32'h0);
        tick();
        chk("jr_p3_valid", {31'h0, id_valid}, 32'h1);
        chk("jr_p3_addr",  imem_addr,         32'h3024);
        pause = 1'b0;
        tick();
        pcsrc = 3'd0;
        chk("jr_skid_pc",    id_pc,             32'h3020);
        chk("jr_skid_instr", id_instr,          32'hCBFF_FFFE);
        chk("jr_target",     imem_addr,         32'h4000);
        chk("jr_req",        {31'h0, imem_req}, 32'h1);

        // ---- Reset while in WAIT, stale response afterwards ----
        resp_en = 1'b0;
        tick();
        chk("rw_grant", last_grant(), 32'h4000);
        rst_n  = 1'b0;
        gnt_en = 1'b0;
        #1;
        chk("rw_req",      {31'h0, imem_req}, 32'h0);
        chk("rw_addr",     imem_addr,         32'h3000);
        chk("rw_id_pc",    id_pc,             32'h3000);
        chk("rw_id_valid", {31'h0, id_valid}, 32'h0);
        #3 rst_n = 1'b1;
        tick();
        resp_en = 1'b1;
        tick();
        chk("late_valid", {31'h0, id_valid}, 32'h0);
        chk("late_instr", id_instr,          32'h0);
        chk("late_req",   {31'h0, imem_req}, 32'h1);
        gnt_en = 1'b1;
        wait_id(8);
        chk("restart_pc",    id_pc,        32'h3000);
        chk("restart_instr", id_instr,     32'h2400_3000);
        chk("restart_grant", last_grant(), 32'h3000);

        // ---- JUMP: {p4[31:28], instr[25:0], 00} ----
        pcsrc = 3'd3;
        tick();
        pcsrc = 3'd0;
        chk("j_target", imem_addr,    32'h0000_C000);
        chk("j_slot",   last_grant(), 32'h3004);
        wait_id(8);
        chk("j_slot_in_id", id_pc, 32'h3004);

        // ---- Misaligned RS target ----
        pcsrc   = 3'd4;
        rs_data = 32'h0000_4002;
        tick();
        pcsrc = 3'd0;
        chk("mis_addr",  imem_addr,    32'h4000);
        chk("mis_grant", last_grant(), 32'h0000_C000);
`ifdef PFU_ALIGN_CHECK_EN
        chk("mis_flag", {31'h0, fetch_misalign}, 32'h1);
        wait_id(8);
        chk("mis_id_pc", id_pc, 32'h0000_C000);
        tick();
        tick();
        chk("mis_req_off",   {31'h0, imem_req},       32'h0);
        chk("mis_addr_hold", imem_addr,               32'h4000);
        chk("mis_sticky",    {31'h0, fetch_misalign}, 32'h1);
`else
        wait_id(8);
        chk("mis_id_pc",  id_pc,             32'h0000_C000);
        chk("mis_req_on", {31'h0, imem_req}, 32'h1);
        tick();
        chk("mis_next_grant", last_grant(), 32'h4000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
